// File: rtl/instruction_decoder_pkg.sv
// Shared decode constants for the ID stage: opcodes, R-type functs, flag encodings, ID/EX record.
// Consumers: opcode_flag_decoder and instruction_decoder (optional LOAD_USE_STALL_EN hazard logic).
package instruction_decoder_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [2:0] OPG_IMM   = 3'b001;
    localparam logic [2:0] OPG_LOAD  = 3'b100;
    localparam logic [2:0] OPG_STORE = 3'b101;

    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_SLLV = 6'b000100;
    localparam logic [5:0] FN_SRLV = 6'b000110;
    localparam logic [5:0] FN_SRAV = 6'b000111;
    localparam logic [5:0] FN_JR   = 6'b001000;
    localparam logic [5:0] FN_JALR = 6'b001001;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;

    // Flag vector: {pc_modify, link_ret, addr_type[1:0], inmediate, mem_op}
    localparam logic [5:0] FLG_NONE   = 6'b000000;
    localparam logic [5:0] FLG_RTYPE  = 6'b000000;
    localparam logic [5:0] FLG_JR     = 6'b100000;
    localparam logic [5:0] FLG_JALR   = 6'b110000;
    localparam logic [5:0] FLG_IMM    = 6'b000010;
    localparam logic [5:0] FLG_MEM    = 6'b000011;
    localparam logic [5:0] FLG_BRANCH = 6'b101010;
    localparam logic [5:0] FLG_J      = 6'b100100;
    localparam logic [5:0] FLG_JAL    = 6'b110100;

    typedef struct packed {
        logic        valid;
        logic [5:0]  flags;
        logic [5:0]  funct;
        logic [4:0]  link_reg;
        logic [4:0]  addr_reg;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [15:0] imm;
        logic [25:0] target;
    } dec_out_t;

    localparam dec_out_t BUBBLE = '0;

    function automatic logic is_alu_funct(input logic [5:0] fn);
        logic ok;
        case (fn)
            FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV,
            FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/instruction_decoder_if.sv
// Fetch-side inputs and ID/EX-side outputs of the decode stage.
interface instruction_decoder_if;
    logic [31:0] i_instr;
    logic        i_instr_valid;
    logic        i_ex_stall;
    logic        i_flush;
    logic        o_stall;
    logic        o_valid;
    logic        o_illegal;
    logic [5:0]  o_funct;
    logic        o_flg_pc_modify;
    logic        o_flg_link_ret;
    logic [1:0]  o_flg_addr_type;
    logic        o_flg_inmediate;
    logic        o_flg_mem_op;
    logic [4:0]  o_link_reg;
    logic [4:0]  o_addr_reg;
    logic [4:0]  o_rs;
    logic [4:0]  o_rt;
    logic [4:0]  o_rd;
    logic [4:0]  o_shamt;
    logic [15:0] o_imm;
    logic [25:0] o_target;

    modport slave (
        input  i_instr, i_instr_valid, i_ex_stall, i_flush,
        output o_stall, o_valid, o_illegal, o_funct,
               o_flg_pc_modify, o_flg_link_ret, o_flg_addr_type, o_flg_inmediate, o_flg_mem_op,
               o_link_reg, o_addr_reg, o_rs, o_rt, o_rd, o_shamt, o_imm, o_target
    );

    modport master (
        output i_instr, i_instr_valid, i_ex_stall, i_flush,
        input  o_stall, o_valid, o_illegal, o_funct,
               o_flg_pc_modify, o_flg_link_ret, o_flg_addr_type, o_flg_inmediate, o_flg_mem_op,
               o_link_reg, o_addr_reg, o_rs, o_rt, o_rd, o_shamt, o_imm, o_target
    );
endinterface

// File: rtl/instruction_decoder_opcode_flag_decoder.sv
// Purely combinational opcode/funct classifier: flag vector, forwarded funct,
// link/address registers and a legal bit for one raw MIPS instruction.
module opcode_flag_decoder
    import instruction_decoder_pkg::*;
(
    input  logic [31:0] instr,
    output logic [5:0]  flags,
    output logic [5:0]  funct,
    output logic [4:0]  link_reg,
    output logic [4:0]  addr_reg,
    output logic        legal
);
    logic [5:0] opcode;
    logic [5:0] fn;
    logic [4:0] rs;
    logic [4:0] rd;
    logic       unused_bits;

    assign opcode      = instr[31:26];
    assign fn          = instr[5:0];
    assign rs          = instr[25:21];
    assign rd          = instr[15:11];
    assign unused_bits = ^{instr[20:16], instr[10:6]};

    // Classify the encoding; anything not recognised is reported as illegal with zero flags.
    always_comb begin
        flags    = FLG_NONE;
        funct    = 6'd0;
        link_reg = 5'd0;
        addr_reg = 5'd0;
        legal    = 1'b1;
        casez (opcode)
            OP_RTYPE: begin
                funct = fn;
                if (fn == FN_JR) begin
                    flags    = FLG_JR;
                    addr_reg = rs;
                end else if (fn == FN_JALR) begin
                    flags    = FLG_JALR;
                    link_reg = rd;
                    addr_reg = rs;
                end else if (is_alu_funct(fn)) begin
                    flags = FLG_RTYPE;
                end else begin
                    funct = 6'd0;
                    legal = 1'b0;
                end
            end
            {OPG_IMM, 3'b???}: begin
                flags = FLG_IMM;
                funct = {3'b000, opcode[2:0]};
            end
            {OPG_LOAD, 3'b???}, {OPG_STORE, 3'b???}: begin
                flags = FLG_MEM;
                funct = opcode;
            end
            OP_BEQ, OP_BNE: begin
                flags = FLG_BRANCH;
                funct = opcode;
            end
            OP_J: begin
                flags = FLG_J;
                funct = opcode;
            end
            OP_JAL: begin
                flags    = FLG_JAL;
                funct    = opcode;
                link_reg = 5'd31;
            end
            default: begin
                flags = FLG_NONE;
                legal = 1'b0;
            end
        endcase
    end
endmodule

// File: rtl/instruction_decoder.sv
// ID stage: decodes i_instr into the ID/EX register, handles flush/stall/bubbles.
// Define LOAD_USE_STALL_EN to enable load-use hazard detection (otherwise load_use is tied 0).
module instruction_decoder
    import instruction_decoder_pkg::*;
(
    input  logic                        i_clk,
    input  logic                        i_reset,
    instruction_decoder_if.slave        bus
);
    logic [5:0] dec_flags;
    logic [5:0] dec_funct;
    logic [4:0] dec_link_reg;
    logic [4:0] dec_addr_reg;
    logic       dec_legal;
    logic       load_use;
    dec_out_t   out_d;
    dec_out_t   out_q;
    logic       illegal_d;
    logic       illegal_q;

    opcode_flag_decoder u_opcode_flag_decoder (
        .instr    (bus.i_instr),
        .flags    (dec_flags),
        .funct    (dec_funct),
        .link_reg (dec_link_reg),
        .addr_reg (dec_addr_reg),
        .legal    (dec_legal)
    );

`ifdef LOAD_USE_STALL_EN
    // A load in ID/EX whose destination is read by the incoming instruction.
    assign load_use = out_q.valid & out_q.flags[0] & (out_q.funct[5:3] == OPG_LOAD)
                    & (out_q.rt != 5'd0) & bus.i_instr_valid
                    & ((bus.i_instr[25:21] == out_q.rt) | (bus.i_instr[20:16] == out_q.rt));
`else
    assign load_use = 1'b0;
`endif

    assign bus.o_stall = ~bus.i_flush & (bus.i_ex_stall | load_use);

    // Next ID/EX contents: flush > hold > load-use bubble > accept.
    always_comb begin
        out_d     = out_q;
        illegal_d = 1'b0;
        if (bus.i_flush) begin
            out_d = BUBBLE;
        end else if (bus.i_ex_stall) begin
            out_d = out_q;
        end else if (load_use) begin
            out_d = BUBBLE;
        end else if (bus.i_instr_valid && dec_legal) begin
            out_d.valid    = 1'b1;
            out_d.flags    = dec_flags;
            out_d.funct    = dec_funct;
            out_d.link_reg = dec_link_reg;
            out_d.addr_reg = dec_addr_reg;
            out_d.rs       = bus.i_instr[25:21];
            out_d.rt       = bus.i_instr[20:16];
            out_d.rd       = bus.i_instr[15:11];
            out_d.shamt    = bus.i_instr[10:6];
            out_d.imm      = bus.i_instr[15:0];
            out_d.target   = bus.i_instr[25:0];
        end else if (bus.i_instr_valid) begin
            out_d     = BUBBLE;
            illegal_d = 1'b1;
        end else begin
            out_d = BUBBLE;
        end
    end

    // ID/EX boundary register with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            out_q     <= BUBBLE;
            illegal_q <= 1'b0;
        end else begin
            out_q     <= out_d;
            illegal_q <= illegal_d;
        end
    end

    assign bus.o_valid         = out_q.valid;
    assign bus.o_illegal       = illegal_q;
    assign bus.o_funct         = out_q.funct;
    assign bus.o_flg_pc_modify = out_q.flags[5];
    assign bus.o_flg_link_ret  = out_q.flags[4];
    assign bus.o_flg_addr_type = out_q.flags[3:2];
    assign bus.o_flg_inmediate = out_q.flags[1];
    assign bus.o_flg_mem_op    = out_q.flags[0];
    assign bus.o_link_reg      = out_q.link_reg;
    assign bus.o_addr_reg      = out_q.addr_reg;
    assign bus.o_rs            = out_q.rs;
    assign bus.o_rt            = out_q.rt;
    assign bus.o_rd            = out_q.rd;
    assign bus.o_shamt         = out_q.shamt;
    assign bus.o_imm           = out_q.imm;
    assign bus.o_target        = out_q.target;
endmodule
